// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parametrised register file.
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } clr_state_t;

   localparam int REGFILE_WIDTH_DEF = 20;
   localparam int REGFILE_DEPTH_DEF = 16;

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback-side bus of the register file: write port, two read ports,
// scoreboard issue/pending and clear control.
interface regfile_if #(
   parameter int WIDTH = 20,
   parameter int AW    = 4
);
   logic             RW;
   logic [AW-1:0]    Dest;
   logic [WIDTH-1:0] Data;
   logic [AW-1:0]    Reg1;
   logic [AW-1:0]    Reg2;
   logic [WIDTH-1:0] out_reg1;
   logic [WIDTH-1:0] out_reg2;
   logic             Issue;
   logic [AW-1:0]    Issue_dest;
   logic             Pend1;
   logic             Pend2;
   logic             Clear;
   logic             Busy;

   modport master (
      output RW, Dest, Data, Reg1, Reg2, Issue, Issue_dest, Clear,
      input  out_reg1, out_reg2, Pend1, Pend2, Busy
   );

   modport slave (
      input  RW, Dest, Data, Reg1, Reg2, Issue, Issue_dest, Clear,
      output out_reg1, out_reg2, Pend1, Pend2, Busy
   );
endinterface

// File: rtl/regfile_clear_seq.sv
// Sequential clear engine: walks idx 0..DEPTH-1, one register per clock,
// raising busy and the sweep-write strobe for exactly DEPTH cycles.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int DEPTH = REGFILE_DEPTH_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   output logic          busy,
   output logic [AW-1:0] idx,
   output logic          sweep_we
);

   clr_state_t state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         busy     <= 1'b0;
         sweep_we <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clear) begin
                  state    <= SWEEP;
                  idx      <= '0;
                  busy     <= 1'b1;
                  sweep_we <= 1'b1;
               end
            end
            SWEEP: begin
               // Clear requests are ignored here; the sweep never restarts.
               if (idx == AW'(DEPTH - 1)) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  sweep_we <= 1'b0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               sweep_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with pending scoreboard, sequential
// clear and optional same-cycle write-to-read forwarding (macro REGFILE_BYPASS_EN).
module regfile_param
   import regfile_pkg::*;
#(
   parameter int WIDTH     = REGFILE_WIDTH_DEF,
   parameter int DEPTH     = REGFILE_DEPTH_DEF,
   parameter int AW        = $clog2(DEPTH),
   parameter int ZERO_REG0 = 0
) (
   input logic      clk,
   input logic      Reset,
   regfile_if.slave bus
);

   // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
   localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] pend;

   logic             busy;
   logic             sweep_we;
   logic [AW-1:0]    sweep_idx;
   logic             wr_ok;
   logic             iss_ok;
   logic [WIDTH-1:0] rd1, rd2;
   logic             pd1, pd2;

   function automatic logic in_range(input logic [AW-1:0] a);
      return ({1'b0, a} < DEPTH_LIM);
   endfunction

   function automatic logic writable(input logic [AW-1:0] a);
      return in_range(a) && !((ZERO_REG0 != 0) && (a == '0));
   endfunction

   regfile_clear_seq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clear_seq (
      .clk      (clk),
      .rst_n    (Reset),
      .clear    (bus.Clear),
      .busy     (busy),
      .idx      (sweep_idx),
      .sweep_we (sweep_we)
   );

   assign wr_ok  = bus.RW && !busy && writable(bus.Dest);
   assign iss_ok = bus.Issue && !busy && writable(bus.Issue_dest);

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         pend <= '0;
      end else if (sweep_we) begin
         regs[sweep_idx] <= '0;
         pend[sweep_idx] <= 1'b0;
      end else begin
         if (wr_ok) begin
            regs[bus.Dest] <= bus.Data;
            pend[bus.Dest] <= 1'b0;
         end
         // Issue is applied after the write so a same-register issue leaves it pending.
         if (iss_ok) begin
            pend[bus.Issue_dest] <= 1'b1;
         end
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic fwd_ok;
   assign fwd_ok = wr_ok && !(iss_ok && (bus.Issue_dest == bus.Dest));
`endif

   always_comb begin
      rd1 = '0;
      pd1 = 1'b0;
      rd2 = '0;
      pd2 = 1'b0;
      if (in_range(bus.Reg1)) begin
         rd1 = regs[bus.Reg1];
         pd1 = pend[bus.Reg1];
      end
      if (in_range(bus.Reg2)) begin
         rd2 = regs[bus.Reg2];
         pd2 = pend[bus.Reg2];
      end
`ifdef REGFILE_BYPASS_EN
      if (fwd_ok && (bus.Reg1 == bus.Dest)) begin
         rd1 = bus.Data;
         pd1 = 1'b0;
      end
      if (fwd_ok && (bus.Reg2 == bus.Dest)) begin
         rd2 = bus.Data;
         pd2 = 1'b0;
      end
`endif
      // Outputs are forced to zero while reset is held, forwarding included.
      if (!Reset) begin
         rd1 = '0;
         pd1 = 1'b0;
         rd2 = '0;
         pd2 = 1'b0;
      end
   end

   assign bus.out_reg1 = rd1;
   assign bus.out_reg2 = rd2;
   assign bus.Pend1    = pd1;
   assign bus.Pend2    = pd2;
   assign bus.Busy     = busy;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (16 regs plain, 12 regs with zero reg)
// driven in lockstep and checked against an array-based reference model.
module tb_regfile_param;

   localparam int W  = 20;
   localparam int AW = 4;
   localparam int D0 = 16;
   localparam int D1 = 12;

   logic clk = 1'b0;
   logic Reset;
   always #5 clk = ~clk;

   logic          rw, iss, clr;
   logic [AW-1:0] dest, r1, r2, idest;
   logic [W-1:0]  data;

   regfile_if #(.WIDTH(W), .AW(AW)) bus0 ();
   regfile_if #(.WIDTH(W), .AW(AW)) bus1 ();

   assign bus0.RW = rw;   assign bus0.Dest = dest;   assign bus0.Data = data;
   assign bus0.Reg1 = r1; assign bus0.Reg2 = r2;     assign bus0.Issue = iss;
   assign bus0.Issue_dest = idest;                   assign bus0.Clear = clr;
   assign bus1.RW = rw;   assign bus1.Dest = dest;   assign bus1.Data = data;
   assign bus1.Reg1 = r1; assign bus1.Reg2 = r2;     assign bus1.Issue = iss;
   assign bus1.Issue_dest = idest;                   assign bus1.Clear = clr;

   regfile_param #(.WIDTH(W), .DEPTH(D0), .ZERO_REG0(0)) dut0 (
      .clk(clk), .Reset(Reset), .bus(bus0));
   regfile_param #(.WIDTH(W), .DEPTH(D1), .ZERO_REG0(1)) dut1 (
      .clk(clk), .Reset(Reset), .bus(bus1));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: contents, pending flags and cycles of clear remaining.
   logic [W-1:0] m_mem  [2][16];
   bit           m_pend [2][16];
   int           m_left [2];
   int           dep    [2] = '{D0, D1};
   int           zr     [2] = '{0, 1};

   function automatic bit m_writable(int k, logic [AW-1:0] a);
      return (int'(a) < dep[k]) && !(zr[k] != 0 && a == 0);
   endfunction

   function automatic bit m_fwd(int k, logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
      return Reset && m_left[k] == 0 && rw && m_writable(k, dest) && a == dest
             && !(iss && idest == dest);
`else
      return (k < 0) && (a != a);
`endif
   endfunction

   function automatic logic [W-1:0] m_rd(int k, logic [AW-1:0] a);
      if (!Reset) return '0;
      if (m_fwd(k, a)) return data;
      return (int'(a) < dep[k]) ? m_mem[k][a] : '0;
   endfunction

   function automatic bit m_pd(int k, logic [AW-1:0] a);
      if (!Reset || m_fwd(k, a)) return 1'b0;
      return (int'(a) < dep[k]) ? m_pend[k][a] : 1'b0;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         m_left[k] = 0;
         for (int i = 0; i < 16; i++) begin
            m_mem[k][i]  = '0;
            m_pend[k][i] = 1'b0;
         end
      end
   endtask

   task automatic m_edge();
      for (int k = 0; k < 2; k++) begin
         if (m_left[k] > 0) begin
            m_mem[k][dep[k] - m_left[k]]  = '0;
            m_pend[k][dep[k] - m_left[k]] = 1'b0;
            m_left[k]--;
         end else begin
            if (rw && m_writable(k, dest)) begin
               m_mem[k][dest]  = data;
               m_pend[k][dest] = 1'b0;
            end
            if (iss && m_writable(k, idest)) m_pend[k][idest] = 1'b1;
            if (clr) m_left[k] = dep[k];
         end
      end
   endtask

   task automatic cmp_one(int k, logic [W-1:0] o1, logic [W-1:0] o2,
                          logic p1, logic p2, logic b);
      check($sformatf("i%0d out_reg1[%0d]", k, r1), 32'(o1), 32'(m_rd(k, r1)));
      check($sformatf("i%0d out_reg2[%0d]", k, r2), 32'(o2), 32'(m_rd(k, r2)));
      check($sformatf("i%0d Pend1[%0d]", k, r1), 32'(p1), 32'(m_pd(k, r1)));
      check($sformatf("i%0d Pend2[%0d]", k, r2), 32'(p2), 32'(m_pd(k, r2)));
      check($sformatf("i%0d Busy", k), 32'(b), 32'(Reset && m_left[k] > 0));
   endtask

   task automatic compare_all();
      cmp_one(0, bus0.out_reg1, bus0.out_reg2, bus0.Pend1, bus0.Pend2, bus0.Busy);
      cmp_one(1, bus1.out_reg1, bus1.out_reg2, bus1.Pend1, bus1.Pend2, bus1.Busy);
   endtask

   // Called 1 time unit after a rising edge with inputs already set.
   task automatic tick();
      #2;
      compare_all();
      @(posedge clk);
      if (Reset) m_edge();
      #1;
   endtask

   task automatic idle();
      rw = 1'b0; iss = 1'b0; clr = 1'b0;
   endtask

   initial begin
      int n;
      Reset = 1'b0;
      idle();
      dest = '0; data = '0; r1 = '0; r2 = '0; idest = '0;
      m_reset();
      #1;
      compare_all();
      check("reset busy", 32'(bus0.Busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      Reset = 1'b1;

      // Basic write/read
      rw = 1'b1; dest = 4'd5; data = 20'h00056;
      tick();
      idle(); r1 = 4'd5; r2 = 4'd2;
      #1;
      check("wr rd reg5", 32'(bus0.out_reg1), 32'h00056);
      check("rd reg2 zero", 32'(bus0.out_reg2), 32'h0);
      tick();

      // Scoreboard
      iss = 1'b1; idest = 4'd6;
      tick();
      idle(); r1 = 4'd6;
      #1;
      check("issue pend", 32'(bus0.Pend1), 32'd1);
      rw = 1'b1; dest = 4'd6; data = 20'h00057;
      tick();
      idle();
      #1;
      check("write clears pend", 32'(bus0.Pend1), 32'd0);
      check("write data reg6", 32'(bus0.out_reg1), 32'h00057);
      rw = 1'b1; dest = 4'd6; data = 20'h00058; iss = 1'b1; idest = 4'd6;
      tick();
      idle();
      #1;
      check("issue wins pend", 32'(bus0.Pend1), 32'd1);
      check("issue wins data", 32'(bus0.out_reg1), 32'h00058);
      tick();

      // Clear sweep
      for (int i = 0; i < 16; i++) begin
         rw = 1'b1; dest = 4'(i); data = 20'(i);
         tick();
      end
      idle(); clr = 1'b1;
      tick();
      clr = 1'b0;
      n = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (!bus0.Busy) break;
         n++;
         if (n == 10) begin
            rw = 1'b1; dest = 4'd3; data = 20'hAAAAA;
         end else begin
            rw = 1'b0;
         end
         tick();
      end
      rw = 1'b0;
      check("clear busy cycles", 32'(n), 32'd16);
      for (int i = 0; i < 16; i++) begin
         r1 = 4'(i);
         #1;
         check($sformatf("swept reg%0d", i), 32'(bus0.out_reg1), 32'h0);
         tick();
      end

      // Reset mid-sweep
      rw = 1'b1; dest = 4'd15; data = 20'h0F0F0; r1 = 4'd15;
      tick();
      idle(); clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (7) tick();
      Reset = 1'b0;
      m_reset();
      #1;
      check("midreset busy", 32'(bus0.Busy), 32'd0);
      check("midreset out_reg1", 32'(bus0.out_reg1), 32'h0);
      compare_all();
      #1;
      Reset = 1'b1;
      rw = 1'b1; dest = 4'd9; data = 20'h00099;
      tick();
      idle(); r1 = 4'd9;
      #1;
      check("post reset write", 32'(bus0.out_reg1), 32'h00099);
      check("post reset busy", 32'(bus0.Busy), 32'd0);

      // Zero register on instance 1
      rw = 1'b1; dest = 4'd0; data = 20'hFFFFF; r1 = 4'd0;
      tick();
      idle();
      #1;
      check("zreg data", 32'(bus1.out_reg1), 32'h0);
      check("reg0 normal", 32'(bus0.out_reg1), 32'hFFFFF);
      iss = 1'b1; idest = 4'd0;
      tick();
      idle();
      #1;
      check("zreg pend", 32'(bus1.Pend1), 32'd0);
      check("reg0 pend normal", 32'(bus0.Pend1), 32'd1);

      // Out-of-range address on the 12-entry instance
      rw = 1'b1; dest = 4'd13; data = 20'h00777; iss = 1'b1; idest = 4'd14;
      tick();
      idle(); r1 = 4'd13; r2 = 4'd14;
      #1;
      check("oor data", 32'(bus1.out_reg1), 32'h0);
      check("oor pend", 32'(bus1.Pend2), 32'd0);
      check("in range 16", 32'(bus0.out_reg1), 32'h00777);

      // Same-cycle write/read
      rw = 1'b1; dest = 4'd4; data = 20'h00444;
      tick();
      rw = 1'b1; dest = 4'd4; data = 20'h12345; r2 = 4'd4;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("bypass out_reg2", 32'(bus0.out_reg2), 32'h12345);
`else
      check("no bypass out_reg2", 32'(bus0.out_reg2), 32'h00444);
`endif
      tick();
      idle();
      #1;
      check("after bypass write", 32'(bus0.out_reg2), 32'h12345);

      // Randomised traffic
      for (int c = 0; c < 600; c++) begin
         rw    = 1'($urandom_range(0, 1));
         dest  = 4'($urandom_range(0, 15));
         data  = 20'($urandom);
         r1    = ($urandom_range(0, 3) == 0) ? dest : 4'($urandom_range(0, 15));
         r2    = 4'($urandom_range(0, 15));
         iss   = ($urandom_range(0, 3) == 0);
         idest = ($urandom_range(0, 3) == 0) ? dest : 4'($urandom_range(0, 15));
         clr   = ($urandom_range(0, 49) == 0);
         tick();
      end
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the 16×20-bit two-read/one-write register file in the datapath, placed between decode (read addresses) and writeback (write port). It adds:

- configurable width and depth;
- an optional hard-wired zero register;
- a per-register pending scoreboard for hazard detection;
- a multi-cycle sequential clear engine;
- optional write-to-read bypass.

## Interface
Parameters:
- WIDTH, 20, data width of each register
- DEPTH, 16, number of registers (2..64, need not be a power of two)
- AW, $clog2(DEPTH), address width (derived, do not override)
- ZERO_REG0, 0, 1 = register 0 reads zero, ignores writes, never pending

Ports:
- clk  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- RW  in  1  write enable for the writeback port
- Dest  in  AW  write address
- Data  in  WIDTH  write data
- Reg1  in  AW  read address, port 1
- Reg2  in  AW  read address, port 2
- out_reg1  out  WIDTH  read data, port 1
- out_reg2  out  WIDTH  read data, port 2
- Issue  in  1  mark Issue_dest as pending (producer in flight)
- Issue_dest  in  AW  register to mark pending
- Pend1  out  1  pending bit of Reg1
- Pend2  out  1  pending bit of Reg2
- Clear  in  1  start a sequential clear of all registers
- Busy  out  1  clear engine active

## Operation
- **Reset (Reset=0, asynchronous):**
  - all registers and pending bits go to 0;
  - FSM goes to IDLE;
  - Busy=0;
  - out_reg1, out_reg2, Pend1 and Pend2 read 0.
- **Reads:** combinational from the array. Address ≥ DEPTH returns 0 and pend 0.
- **Write:** at the clock edge, when RW=1, Busy=0, Dest<DEPTH, and Dest≠0 (only when ZERO_REG0=1), the register is updated and its pending bit is cleared.
- **Issue:** at the clock edge, when Issue=1 and Busy=0, the pending bit of Issue_dest is set.
  - If Issue and a write target the same register in the same cycle, the data is written and pending ends at 1 (Issue wins).
  - Issue_dest ≥ DEPTH is ignored.
- **Clear FSM, states IDLE and SWEEP:**
  - IDLE → SWEEP when Clear=1 at the edge. The index counter loads 0 and Busy rises in the next cycle.
  - In SWEEP, each edge zeroes register[idx] and pending[idx], then increments idx.
  - SWEEP → IDLE at the edge where idx=DEPTH-1. The last register is zeroed on that edge.
  - Clear asserted while in SWEEP is ignored; the sweep does not restart.
  - RW and Issue are ignored for the whole SWEEP.
  - Reads during SWEEP return current contents: already-swept entries read 0.
- **Reset mid-sweep:** aborts the sweep immediately; everything returns to reset values.

## Timing
- Read latency is 0 cycles (combinational); the write is visible from the cycle after its edge.
- A Clear sampled at edge N gives:
  - Busy=1 from after edge N through after edge N+DEPTH-1;
  - Busy=0 after edge N+DEPTH;
  - DEPTH cycles of Busy in total.
- A write accepted in the same cycle that Clear is sampled in IDLE completes. The sweep later zeroes that register.
- Pend1 and Pend2 are combinational from the pending register. A set or clear is visible the cycle after its edge.

## Configuration
- REGFILE_BYPASS_EN defined:
  - if RW=1, Busy=0, Dest is writable, and RegN==Dest, out_regN=Data and PendN=0 in the same cycle (forwarding);
  - this holds unless Issue also targets that register.
- REGFILE_BYPASS_EN undefined: reads return the array contents only, so a same-cycle write is seen one cycle later.

## Structure
- Package regfile_pkg holds:
  - the FSM state typedef (IDLE, SWEEP);
  - default WIDTH and DEPTH constants.
- One sub-module, regfile_clear_seq: owns the FSM and the index counter, and outputs Busy, the sweep index and the sweep-write strobe.
- The top level owns the array, the pending vector, read muxing and bypass.

## Test plan
- **Write/read:** reset, RW=1, Dest=5, Data=0x00056, one edge, then Reg1=5 → out_reg1=0x00056; Reg2=2 → out_reg2=0.
- **Scoreboard:**
  - Issue=1, Issue_dest=6, edge, Reg1=6 → Pend1=1;
  - then RW=1, Dest=6, Data=0x00057, edge → Pend1=0 and out_reg1=0x00057;
  - Issue and RW both targeting 6 on the same edge → Pend1=1 and data updated.
- **Clear:**
  - fill registers 0..15 with their index, pulse Clear;
  - Busy stays high for exactly 16 cycles;
  - a write to register 3 during Busy is dropped;
  - afterwards all registers read 0.
- **Reset mid-sweep:** assert Reset=0 at sweep cycle 7 → Busy=0 immediately, all outputs 0; deassert, then a write works on the next edge.
- **ZERO_REG0=1:** RW=1, Dest=0, Data=0xFFFFF → out_reg1 (Reg1=0) stays 0; Issue on register 0 → Pend1 stays 0.
- **Bypass (REGFILE_BYPASS_EN):** RW=1, Dest=4, Data=0x12345, Reg2=4 in the same cycle → out_reg2=0x12345 before the edge. Without the macro, out_reg2 shows the old value.
